// File: rtl/fpu_seq.sv
// Multi-cycle start/busy/ready sequencer around a combinational FPU.
// Holds registered operands stable for LATENCY cycles, then captures the FPU result.
module fpu_seq #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  reg_waddr_i,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  output logic [1:0]  fpu_op_o,
  input  logic [31:0] fpu_result_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [4:0]  reg_waddr_o
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 2;
  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  fpu_a_q, fpu_a_d;
  logic [DW-1:0]  fpu_b_q, fpu_b_d;
  logic [OPW-1:0] fpu_op_q, fpu_op_d;
  logic [DW-1:0]  result_q, result_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;

  // Next-state and registered-output logic; abort wins over completion in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fpu_a_d  = fpu_a_q;
    fpu_b_d  = fpu_b_q;
    fpu_op_d = fpu_op_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          fpu_a_d  = a_i;
          fpu_b_d  = b_i;
          fpu_op_d = op_i;
          waddr_d  = reg_waddr_i;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!start_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = fpu_result_i;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // start_i deliberately ignored here so a stale request cannot re-trigger.
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fpu_a_q  <= '0;
      fpu_b_q  <= '0;
      fpu_op_q <= '0;
      result_q <= '0;
      waddr_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fpu_a_q  <= fpu_a_d;
      fpu_b_q  <= fpu_b_d;
      fpu_op_q <= fpu_op_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign fpu_a_o     = fpu_a_q;
  assign fpu_b_o     = fpu_b_q;
  assign fpu_op_o    = fpu_op_q;
  assign result_o    = result_q;
  assign reg_waddr_o = waddr_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Directed self-checking bench for fpu_seq at LATENCY=3 (u3) and LATENCY=1 (u1).
module tb_fpu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start1;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [4:0]  waddr;

  logic [31:0] fa3, fb3, res3, fres3;
  logic [1:0]  fop3;
  logic        rdy3, busy3;
  logic [4:0]  wa3;

  logic [31:0] fa1, fb1, res1, fres1;
  logic [1:0]  fop1;
  logic        rdy1, busy1;
  logic [4:0]  wa1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Tiny FPU model: knows only the vectors used below; anything else yields DEADBEEF.
  function automatic logic [31:0] fpu_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    if (o == 2'd0 && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
    if (o == 2'd1 && x == 32'h40400000 && y == 32'h3F800000) return 32'h40000000;
    if (o == 2'd2 && x == 32'h40000000 && y == 32'h40400000) return 32'h40C00000;
    if (o == 2'd3 && x == 32'h40C00000 && y == 32'h40000000) return 32'h40400000;
    return 32'hDEADBEEF;
  endfunction

  assign fres3 = fpu_model(fop3, fa3, fb3);
  assign fres1 = fpu_model(fop1, fa1, fb1);

  fpu_seq #(.LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .start_i(start3), .op_i(op), .a_i(a), .b_i(b),
    .reg_waddr_i(waddr), .fpu_a_o(fa3), .fpu_b_o(fb3), .fpu_op_o(fop3),
    .fpu_result_i(fres3), .result_o(res3), .ready_o(rdy3), .busy_o(busy3),
    .reg_waddr_o(wa3)
  );

  fpu_seq #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op), .a_i(a), .b_i(b),
    .reg_waddr_i(waddr), .fpu_a_o(fa1), .fpu_b_o(fb1), .fpu_op_o(fop1),
    .fpu_result_i(fres1), .result_o(res1), .ready_o(rdy1), .busy_o(busy1),
    .reg_waddr_o(wa1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; start3 = 1'b0; start1 = 1'b0;
    op = 2'd0; a = '0; b = '0; waddr = '0;
    tick(); tick();
    chk("rst_busy",  32'(busy3), 32'd0);
    chk("rst_ready", 32'(rdy3),  32'd0);
    chk("rst_res",   res3,       32'd0);
    chk("rst_fa",    fa3,        32'd0);
    chk("rst_waddr", 32'(wa3),   32'd0);
    rst = 1'b1;
    tick();

    // Basic add with operands wiggled during RUN
    a = 32'h3F800000; b = 32'h40000000; op = 2'd0; waddr = 5'd5; start3 = 1'b1;
    tick(); // cycle 1
    chk("add_c1_busy",  32'(busy3), 32'd1);
    chk("add_c1_ready", 32'(rdy3),  32'd0);
    chk("add_c1_fa",    fa3,        32'h3F800000);
    a = 32'h11111111; b = 32'h22222222; op = 2'd3; waddr = 5'd7;
    tick(); // cycle 2
    chk("add_c2_fa",    fa3,        32'h3F800000);
    chk("add_c2_fb",    fb3,        32'h40000000);
    chk("add_c2_busy",  32'(busy3), 32'd1);
    a = 32'h33333333; b = 32'h44444444;
    tick(); // cycle 3
    chk("add_c3_busy",  32'(busy3), 32'd1);
    chk("add_c3_ready", 32'(rdy3),  32'd0);
    chk("add_c3_op",    32'(fop3),  32'd0);
    tick(); // cycle 4
    chk("add_c4_ready", 32'(rdy3),  32'd1);
    chk("add_c4_busy",  32'(busy3), 32'd0);
    chk("add_c4_res",   res3,       32'h40400000);
    chk("add_c4_waddr", 32'(wa3),   32'd5);
    start3 = 1'b0;
    tick(); // cycle 5
    chk("add_c5_ready", 32'(rdy3),  32'd0);
    chk("add_c5_res",   res3,       32'h40400000);

    // Abort a mul in cycle 2
    a = 32'h40000000; b = 32'h40400000; op = 2'd2; waddr = 5'd9; start3 = 1'b1;
    tick(); // cycle 1
    chk("ab_c1_op",   32'(fop3),  32'd2);
    tick(); // cycle 2
    start3 = 1'b0;
    tick(); // cycle 3
    chk("ab_c3_busy", 32'(busy3), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ab_noready", 32'(rdy3), 32'd0);
      tick();
    end
    chk("ab_res_keep", res3, 32'h40400000);

    // Faulty requester holds start through DONE and beyond
    a = 32'h40400000; b = 32'h3F800000; op = 2'd1; waddr = 5'd3; start3 = 1'b1;
    tick(); tick(); tick();
    chk("sr_c3_ready", 32'(rdy3), 32'd0);
    tick(); // cycle 4
    chk("sr_c4_ready", 32'(rdy3), 32'd1);
    chk("sr_c4_res",   res3,      32'h40000000);
    tick(); // cycle 5: back in IDLE, start still high
    chk("sr_c5_ready", 32'(rdy3),  32'd0);
    chk("sr_c5_busy",  32'(busy3), 32'd0);
    a = 32'h40C00000; b = 32'h40000000; op = 2'd3; waddr = 5'd12;
    tick(); // cycle 6
    chk("sr_c6_busy",  32'(busy3), 32'd1);
    tick(); tick(); // cycle 8
    chk("sr_c8_ready", 32'(rdy3),  32'd0);
    tick(); // cycle 9
    chk("sr_c9_ready", 32'(rdy3),  32'd1);
    chk("sr_c9_res",   res3,       32'h40400000);
    chk("sr_c9_waddr", 32'(wa3),   32'd12);
    start3 = 1'b0;
    tick();
    chk("sr_c10_ready", 32'(rdy3), 32'd0);

    // Reset mid-RUN
    a = 32'h3F800000; b = 32'h40000000; op = 2'd0; waddr = 5'd5; start3 = 1'b1;
    tick(); tick(); // cycle 2
    rst = 1'b0;
    #1;
    chk("mr_busy",  32'(busy3), 32'd0);
    chk("mr_ready", 32'(rdy3),  32'd0);
    chk("mr_res",   res3,       32'd0);
    chk("mr_fa",    fa3,        32'd0);
    chk("mr_waddr", 32'(wa3),   32'd0);
    start3 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    a = 32'h40000000; b = 32'h40400000; op = 2'd2; waddr = 5'd9; start3 = 1'b1;
    tick(); tick(); tick(); // cycle 3
    chk("mr2_c3_ready", 32'(rdy3), 32'd0);
    tick(); // cycle 4
    chk("mr2_c4_ready", 32'(rdy3), 32'd1);
    chk("mr2_c4_res",   res3,      32'h40C00000);
    chk("mr2_c4_waddr", 32'(wa3),  32'd9);
    start3 = 1'b0;
    tick();

    // LATENCY=1 back-to-back
    a = 32'h3F800000; b = 32'h40000000; op = 2'd0; waddr = 5'd5; start1 = 1'b1;
    tick(); // cycle 1
    chk("l1_c1_busy",  32'(busy1), 32'd1);
    chk("l1_c1_ready", 32'(rdy1),  32'd0);
    tick(); // cycle 2
    chk("l1_c2_ready", 32'(rdy1),  32'd1);
    chk("l1_c2_busy",  32'(busy1), 32'd0);
    chk("l1_c2_res",   res1,       32'h40400000);
    chk("l1_c2_waddr", 32'(wa1),   32'd5);
    start1 = 1'b0;
    tick(); // cycle 3 (IDLE)
    chk("l1_c3_ready", 32'(rdy1),  32'd0);
    a = 32'h40000000; b = 32'h40400000; op = 2'd2; waddr = 5'd9; start1 = 1'b1;
    tick(); // cycle 4
    chk("l1_c4_busy",  32'(busy1), 32'd1);
    tick(); // cycle 5
    chk("l1_c5_ready", 32'(rdy1),  32'd1);
    chk("l1_c5_res",   res1,       32'h40C00000);
    chk("l1_c5_waddr", 32'(wa1),   32'd9);
    start1 = 1'b0;
    tick();
    chk("l1_c6_ready", 32'(rdy1),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
# fpu_seq

Multi-cycle sequencer for the floating-point unit. It sits between the execute stage and the combinational FPU and gives the FPU a start/busy/ready handshake like the divider's. It registers the operands and opcode and holds them stable for LATENCY cycles, so the FPU's long combinational path is a legal multicycle path. It then captures the result and returns it to execute with the destination float-register address.

## Interface
Parameters:
- LATENCY, 3, number of cycles operands are held before the FPU output is sampled; legal range 1..15.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request from execute; held high for the whole operation; dropping it aborts.
- op_i  in  2  FPU opcode, passed through uninterpreted (00 add, 01 sub, 10 mul, 11 div).
- a_i  in  32  operand A.
- b_i  in  32  operand B.
- reg_waddr_i  in  5  destination float-register address.
- fpu_a_o  out  32  registered operand A to the FPU.
- fpu_b_o  out  32  registered operand B to the FPU.
- fpu_op_o  out  2  registered opcode to the FPU.
- fpu_result_i  in  32  combinational FPU result.
- result_o  out  32  captured result, valid while ready_o is high.
- ready_o  out  1  one-cycle completion pulse.
- busy_o  out  1  operation in progress.
- reg_waddr_o  out  5  latched destination address, valid with ready_o.

## Operation
States are IDLE, RUN and DONE, plus a 4-bit counter cnt. All outputs are registered.

- **Reset (rst low, asynchronous):**
  - State goes to IDLE and cnt to 0.
  - fpu_a_o, fpu_b_o, fpu_op_o, result_o, reg_waddr_o, ready_o and busy_o all go to 0.
- **IDLE:**
  - ready_o <= 0.
  - If start_i=1 at the clock edge:
    - a_i→fpu_a_o, b_i→fpu_b_o, op_i→fpu_op_o, reg_waddr_i→reg_waddr_o.
    - cnt <= 0, busy_o <= 1, go to RUN.
  - Otherwise stay in IDLE. Operand registers keep their last values.
- **RUN:**
  - If start_i=0 (abort from a flush, jump or interrupt):
    - Go to IDLE with busy_o <= 0.
    - No ready pulse; result_o is unchanged.
    - Abort has priority over completion in the same cycle.
  - Else if cnt == LATENCY-1:
    - result_o <= fpu_result_i, ready_o <= 1, busy_o <= 0, go to DONE.
  - Else cnt <= cnt+1.
  - fpu_a_o, fpu_b_o and fpu_op_o do not change while in RUN. Changes to a_i, b_i, op_i and reg_waddr_i during RUN are ignored.
- **DONE:**
  - Execute sees ready_o, writes the float register and drops start_i in this same cycle.
  - Next edge: ready_o <= 0 and go to IDLE unconditionally. start_i is not sampled in DONE, so a stale start_i cannot restart the operation.
- result_o and reg_waddr_o hold their values after DONE until the next completion or the next start.

## Timing
- Cycle 0: start_i is high and sampled at the end of the cycle.
- Cycles 1..LATENCY: busy_o=1 and the FPU inputs are stable.
- End of cycle LATENCY: the FPU output is sampled.
- Cycle LATENCY+1: ready_o=1 and busy_o=0.
- Total latency is LATENCY+1 cycles from the first sampled start_i to ready_o.
- With LATENCY=1 the block is in RUN for one cycle; ready_o is high in cycle 2.
- Back-to-back: the earliest next start is sampled in the IDLE cycle after DONE, i.e. LATENCY+2 cycles of throughput per operation.
- busy_o and ready_o are never high in the same cycle.
- A reset mid-operation clears everything immediately. No ready pulse is produced.

## Test plan
- **Basic add:** LATENCY=3, start_i held, a_i=0x3F800000, b_i=0x40000000, op_i=00, reg_waddr_i=5; FPU model returns 0x40400000.
  -> busy_o high cycles 1–3, ready_o high only in cycle 4, result_o=0x40400000, reg_waddr_o=5.
- **Operand stability:** change a_i and b_i every cycle during RUN.
  -> fpu_a_o and fpu_b_o stay equal to the cycle-0 values; result is correct.
- **Abort:** drop start_i in cycle 2 of a LATENCY=3 mul.
  -> busy_o=0 from cycle 3, ready_o is never asserted, result_o keeps its previous value.
- **No spurious restart:** hold start_i high through DONE for one extra cycle (faulty requester).
  -> exactly one ready pulse; the block is back in IDLE, then restarts only because start_i is still high in IDLE. Check the second pulse lands at +LATENCY+1 from that sample.
- **Reset mid-RUN:** rst=0 in cycle 2.
  -> all outputs are 0 asynchronously. After release, a new start completes with nominal latency.
- **LATENCY=1 corner and back-to-back:** two operations issued as fast as allowed.
  -> ready_o in cycles 2 and 5; results and reg_waddr_o match each request.
